// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the DMA/loader port and the single-port dmem.
// Optional perf counters appear when DMEM_ARB_PERF_EN is defined.
interface dmem_arbiter_if;
  logic        core_req;
  logic        core_we;
  logic [3:0]  core_be;
  logic [29:0] core_addr;
  logic [31:0] core_wd;
  logic [31:0] core_rd;
  logic        core_stall;

  logic        dma_valid;
  logic        dma_ready;
  logic        dma_we;
  logic [3:0]  dma_be;
  logic [29:0] dma_addr;
  logic [31:0] dma_wd;
  logic [7:0]  dma_burst_len;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;

  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_core_stall_cnt;
  logic [31:0] perf_dma_beats;
  logic [31:0] perf_forced_cnt;
`endif

  // Arbiter side
  modport slave (
`ifdef DMEM_ARB_PERF_EN
    output perf_core_stall_cnt, perf_dma_beats, perf_forced_cnt,
`endif
    input  core_req, core_we, core_be, core_addr, core_wd,
    output core_rd, core_stall,
    input  dma_valid, dma_we, dma_be, dma_addr, dma_wd, dma_burst_len,
    output dma_ready, dma_rdata, dma_rvalid,
    output mem_we, mem_be, mem_addr, mem_wd,
    input  mem_rd
  );

  // Environment side: requesters plus the memory read path
  modport master (
`ifdef DMEM_ARB_PERF_EN
    input  perf_core_stall_cnt, perf_dma_beats, perf_forced_cnt,
`endif
    output core_req, core_we, core_be, core_addr, core_wd,
    input  core_rd, core_stall,
    output dma_valid, dma_we, dma_be, dma_addr, dma_wd, dma_burst_len,
    input  dma_ready, dma_rdata, dma_rvalid,
    input  mem_we, mem_be, mem_addr, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Core/DMA arbiter for the single-port data memory: core priority, bounded DMA wait,
// locked DMA bursts. Define DMEM_ARB_PERF_EN to add stall/beat/force counters.
module dmem_arbiter #(
  parameter int MAX_WAIT  = 8,
  parameter int MAX_BURST = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [7:0] MAX_WAIT_C  = 8'(MAX_WAIT);
  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  state_t      state_reg, state_next;
  logic [7:0]  beat_cnt_reg, beat_cnt_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic        dma_rvalid_reg;
  logic [31:0] dma_rdata_reg;
  logic        grant_core, grant_dma, force_grant;
  logic [7:0]  eff_len;

  always_comb begin
    eff_len = bus.dma_burst_len;
    if (eff_len == 8'd0)
      eff_len = 8'd1;
    if (eff_len > MAX_BURST_C)
      eff_len = MAX_BURST_C;
  end

  always_comb begin
    grant_core    = 1'b0;
    grant_dma     = 1'b0;
    force_grant   = 1'b0;
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        force_grant = bus.dma_valid && (wait_cnt_reg >= MAX_WAIT_C);
        if (force_grant)
          grant_dma = 1'b1;
        else if (bus.core_req)
          grant_core = 1'b1;
        else if (bus.dma_valid)
          grant_dma = 1'b1;
        if (grant_dma && eff_len > 8'd1) begin
          state_next    = BURST;
          beat_cnt_next = eff_len - 8'd1;
        end
      end
      BURST: begin
        // A gap in dma_valid lends the slot to the core without consuming a beat
        if (bus.dma_valid)
          grant_dma = 1'b1;
        else if (bus.core_req)
          grant_core = 1'b1;
        if (grant_dma) begin
          if (beat_cnt_reg <= 8'd1) begin
            beat_cnt_next = 8'd0;
            state_next    = IDLE;
          end else begin
            beat_cnt_next = beat_cnt_reg - 8'd1;
          end
        end
      end
      default: begin
        state_next    = IDLE;
        beat_cnt_next = 8'd0;
      end
    endcase
  end

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!bus.dma_valid || grant_dma)
      wait_cnt_next = 8'd0;
    else if (wait_cnt_reg != 8'hFF)
      wait_cnt_next = wait_cnt_reg + 8'd1;
  end

  assign bus.dma_ready  = grant_dma;
  assign bus.core_stall = bus.core_req && !grant_core;
  assign bus.core_rd    = bus.mem_rd;
  assign bus.dma_rdata  = dma_rdata_reg;
  assign bus.dma_rvalid = dma_rvalid_reg;

  // Idle cycles park the address/data on the core so only we/be need gating
  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_be   = 4'h0;
    bus.mem_addr = bus.core_addr;
    bus.mem_wd   = bus.core_wd;
    if (grant_dma) begin
      bus.mem_we   = bus.dma_we;
      bus.mem_be   = bus.dma_be;
      bus.mem_addr = bus.dma_addr;
      bus.mem_wd   = bus.dma_wd;
    end else if (grant_core) begin
      bus.mem_we   = bus.core_we;
      bus.mem_be   = bus.core_be;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      beat_cnt_reg   <= 8'd0;
      wait_cnt_reg   <= 8'd0;
      dma_rvalid_reg <= 1'b0;
      dma_rdata_reg  <= 32'd0;
    end else begin
      state_reg      <= state_next;
      beat_cnt_reg   <= beat_cnt_next;
      wait_cnt_reg   <= wait_cnt_next;
      dma_rvalid_reg <= grant_dma && !bus.dma_we;
      if (grant_dma && !bus.dma_we)
        dma_rdata_reg <= bus.mem_rd;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_reg, perf_beats_reg, perf_forced_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_reg  <= 32'd0;
      perf_beats_reg  <= 32'd0;
      perf_forced_reg <= 32'd0;
    end else begin
      if (bus.core_stall)
        perf_stall_reg <= perf_stall_reg + 32'd1;
      if (grant_dma)
        perf_beats_reg <= perf_beats_reg + 32'd1;
      if (force_grant)
        perf_forced_reg <= perf_forced_reg + 32'd1;
    end
  end

  assign bus.perf_core_stall_cnt = perf_stall_reg;
  assign bus.perf_dma_beats      = perf_beats_reg;
  assign bus.perf_forced_cnt     = perf_forced_reg;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (core port) and a DMA/loader port (valid/ready).
- Sits between mem_stage and dmem. Drives dmem we/byteEnable/address/wd and returns dmem rd to the winner.
- Core has default priority. A wait counter bounds DMA starvation. DMA bursts lock the memory for a bounded number of beats, stalling the core.

Parameters:
- MAX_WAIT, 8, consecutive cycles the DMA may wait with dma_valid=1 before forcing one beat; range 1..255.
- MAX_BURST, 16, cap on locked burst beats; larger dma_burst_len is clipped to it; range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- core_req  in  1  MEM stage access this cycle (load or store)
- core_we  in  1  store
- core_be  in  4  byte enables from wdext
- core_addr  in  30  word address (ALUResult[31:2])
- core_wd  in  32  store data
- core_rd  out  32  read data to loadext; combinational passthrough of mem_rd
- core_stall  out  1  hold the MEM stage and all earlier stages
- dma_valid  in  1  DMA beat request
- dma_ready  out  1  beat accepted this cycle
- dma_we  in  1  DMA write
- dma_be  in  4  DMA byte enables
- dma_addr  in  30  DMA word address
- dma_wd  in  32  DMA write data
- dma_burst_len  in  8  beats in the burst; sampled on the first accepted beat only; 0 is treated as 1
- dma_rdata  out  32  registered read data
- dma_rvalid  out  1  pulses the cycle after an accepted DMA read beat
- mem_we  out  1  to dmem we
- mem_be  out  4  to dmem byteEnable
- mem_addr  out  30  to dmem address
- mem_wd  out  32  to dmem wd
- mem_rd  in  32  from dmem rd (combinational read)

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst_n is asynchronous, active-low.
- Reset values:
  - FSM=IDLE, beat_cnt=0, wait_cnt=0.
  - dma_rvalid=0, dma_rdata=0.
  - Combinational outputs follow the IDLE rules with the current inputs.
- Memory timing: dmem reads are combinational and writes are synchronous, so each granted beat completes in its own cycle.
- Grant is computed combinationally each cycle. At most one grant per cycle.
- FSM states: IDLE, BURST.
- IDLE grant:
  - force = dma_valid && wait_cnt >= MAX_WAIT.
  - If force: grant DMA.
  - Else if core_req: grant core.
  - Else if dma_valid: grant DMA.
- BURST grant:
  - If dma_valid: grant DMA.
  - Else if core_req: grant core. The gap beat goes to the core and beat_cnt is held.
- IDLE -> BURST on an accepted DMA beat with effective len = min(max(dma_burst_len,1), MAX_BURST) > 1. beat_cnt loads len-1.
- In BURST, each accepted DMA beat decrements beat_cnt. The beat that takes beat_cnt from 1 to 0 returns the FSM to IDLE.
- Forced beats in IDLE also start bursts.
- wait_cnt:
  - Increments (saturating at 255) when dma_valid=1 and no DMA grant.
  - Clears on any DMA grant or when dma_valid=0.
- Port outputs:
  - dma_ready = DMA grant.
  - core_stall = core_req && !core-grant.
  - core_rd = mem_rd always.
- Memory outputs:
  - Muxed from the granted port.
  - With no grant: mem_we=0, mem_be=0, mem_addr=core_addr, mem_wd=core_wd.
  - A stalled core must never write.
- dma_rdata/dma_rvalid: registered on an accepted beat with dma_we=0. dma_rvalid=0 on write beats and idle cycles.
- Simultaneous core_req and forced DMA: DMA wins, core stalls exactly 1 cycle (unless a burst starts).
- The core holds its request stable while stalled (pipeline guarantee). The arbiter does not latch core signals.
- Reset asserted mid-burst: FSM returns to IDLE immediately and the remaining beats are dropped. The DMA re-issues after reset.
- Worst-case core stall = MAX_BURST cycles per burst.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_core_stall_cnt[31:0], perf_dma_beats[31:0] and perf_forced_cnt[31:0].
  - These are wrapping counters of core_stall cycles, accepted DMA beats and force grants.
  - All reset to 0 on rst_n.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0 with core_req=1, core_we=1 -> mem_we=1 from the core grant. Then release, core_req=0, dma_valid=0 -> mem_we=0, mem_be=0, dma_rvalid=0, core_stall=0.
- Core priority: core_req=1 and dma_valid=1 (len=1) for 3 cycles -> core granted each cycle, dma_ready=0. With core_req held 1, DMA is forced on the cycle wait_cnt reaches 8: dma_ready=1, core_stall=1 for exactly that cycle, wait_cnt=0.
- DMA read: dma_valid=1, dma_we=0, addr=0x10 holding 0xDEADBEEF, core idle -> dma_ready=1. Next cycle dma_rvalid=1, dma_rdata=0xDEADBEEF.
- Burst lock: len=4 accepted, core_req=1 from the next cycle -> core_stall=1 for 3 cycles, then core granted. Drop dma_valid for 1 mid-burst cycle -> core gets that beat and the burst still totals 4 DMA beats.
- Clip and zero length: len=200 -> exactly 16 locked beats. len=0 -> single beat, FSM stays IDLE.
- Stalled store: core_we=1, core_be=4'hF stalled during a burst -> target word unchanged until the grant cycle, then written once. Assert reset mid-burst -> FSM=IDLE, core granted next cycle.
